transmissor_hps: RTL
====================

TRANSMISSOR_HPS -- requirements
Module: transmissor_hps

Interface
REQ-001 Parameter LARGURA, default 8, width in bits of each result word.
REQ-002 Parameter PROFUNDIDADE, default 4, number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 clk  in  1  single clock; all registers update on the falling edge of clk.
REQ-004 reset  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 dado_in  in  LARGURA  result word from the coprocessor datapath.
REQ-006 valido_in  in  1  dado_in valid; a write occurs on an edge where valido_in=1 and pronto_out=1.
REQ-007 pronto_out  out  1  FIFO can accept a word.
REQ-008 dado_hps  out  LARGURA  word presented to the HPS.
REQ-009 req_hps  out  1  4-phase request to the HPS; dado_hps valid while high.
REQ-010 ack_hps  in  1  4-phase acknowledge from the HPS; asynchronous to clk.
REQ-011 fifo_vazia  out  1  FIFO holds zero words.
REQ-012 fifo_cheia  out  1  FIFO holds PROFUNDIDADE words.
REQ-013 contagem  out  clog2(PROFUNDIDADE)+1  words currently stored.

Function
REQ-014 ack_hps SHALL pass through a two-flop synchronizer before use (ack_sinc); no other logic SHALL sample raw ack_hps.
REQ-015 FIFO: circular buffer, write/read pointers wrap modulo PROFUNDIDADE, contagem tracks occupancy exactly.
REQ-016 pronto_out = reset & ~fifo_cheia (combinational); a write while full SHALL be ignored and contents unchanged.
REQ-017 Read (pop) occurs only from FSM state OCIOSO when fifo_vazia=0.
REQ-018 Simultaneous write and read on one edge: both take effect, contagem unchanged.
REQ-019 Write into empty FIFO and FSM in OCIOSO: word is stored at that edge, popped on the next edge (no bypass).
REQ-020 FSM states: OCIOSO, REQ_ALTO, REQ_BAIXO.
REQ-021 OCIOSO: if fifo_vazia=0 and ack_sinc=0 -> pop, load dado_hps with head word, req_hps<=1, go REQ_ALTO; else stay.
REQ-022 REQ_ALTO: hold dado_hps and req_hps=1; on ack_sinc=1 -> req_hps<=0, go REQ_BAIXO.
REQ-023 REQ_BAIXO: req_hps=0, dado_hps held; on ack_sinc=0 -> go OCIOSO.
REQ-024 dado_hps SHALL change only on the OCIOSO->REQ_ALTO transition.
REQ-025 Latency: valido_in sampled into empty FIFO in OCIOSO -> req_hps high on the 2nd following falling edge.
REQ-026 ack_hps rising -> req_hps low on the 3rd falling edge after ack_hps is first stable high (2 sync + 1 FSM).
REQ-027 ack_hps held high in OCIOSO (spurious) SHALL block new requests until it returns low.
REQ-028 Words SHALL be delivered to the HPS in write order, none duplicated or lost while pronto_out was honoured.

Reset
REQ-029 With reset=0 at a falling edge: pointers and contagem=0, fifo_vazia=1, fifo_cheia=0, req_hps=0, dado_hps=0, synchronizer flops=0, FSM=OCIOSO.
REQ-030 pronto_out SHALL be 0 while reset=0.
REQ-031 Reset mid-handshake SHALL abandon the word in flight and clear the FIFO; req_hps drops at that edge.

Verification
REQ-032 Single word: write 0xA5 to empty FIFO, HPS acks after 5 cycles -> dado_hps=0xA5, req_hps high 2 edges after write, low 3 edges after ack, FSM returns OCIOSO after ack low.
REQ-033 Fill: write 0x01..0x05 back-to-back, HPS never acks -> first word in dado_hps, 0x02..0x05 stored, fifo_cheia=1, pronto_out=0, 6th write ignored.
REQ-034 Order/wrap: stream 10 words 0x10..0x19 with HPS acking each -> HPS receives 0x10..0x19 in order, pointers wrap twice, fifo_vazia=1 at end.
REQ-035 Simultaneous: FIFO holding 2 words, write and pop on same edge -> contagem stays 2, no word lost.
REQ-036 Reset mid-op: 3 words stored, req_hps=1, assert reset=0 one edge -> req_hps=0, contagem=0, dado_hps=0, fifo_vazia=1.
REQ-037 Spurious ack: ack_hps=1 in OCIOSO with FIFO non-empty -> req_hps stays 0 until ack_hps low, then asserts.

Source files
------------

// File: rtl/transmissor_hps.sv
// Result-word transmitter: circular FIFO feeding a 4-phase req/ack handshake to the HPS.
// All state updates on the falling edge of clk; ack_hps is asynchronous and is synchronized first.
`timescale 1ns/1ps
module transmissor_hps #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LARGURA-1:0]              dado_in,
  input  logic                            valido_in,
  output logic                            pronto_out,
  output logic [LARGURA-1:0]              dado_hps,
  output logic                            req_hps,
  input  logic                            ack_hps,
  output logic                            fifo_vazia,
  output logic                            fifo_cheia,
  output logic [$clog2(PROFUNDIDADE):0]   contagem
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {OCIOSO, REQ_ALTO, REQ_BAIXO} estado_t;

  estado_t             estado_q, estado_d;
  logic                ack_s1_q, ack_sinc_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LARGURA-1:0]  dado_q, dado_d;
  logic                req_q, req_d;
  logic [LARGURA-1:0]  mem_q [PROFUNDIDADE];
  logic                wr_en, rd_en;

  assign fifo_vazia = (cnt_q == '0);
  assign fifo_cheia = (cnt_q == CW'(PROFUNDIDADE));
  assign pronto_out = reset & ~fifo_cheia;
  assign wr_en      = valido_in & pronto_out;
  assign contagem   = cnt_q;
  assign dado_hps   = dado_q;
  assign req_hps    = req_q;

  // Two-flop synchronizer: the only consumer of raw ack_hps.
  always_ff @(negedge clk) begin
    if (!reset) begin
      ack_s1_q   <= 1'b0;
      ack_sinc_q <= 1'b0;
    end else begin
      ack_s1_q   <= ack_hps;
      ack_sinc_q <= ack_s1_q;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(negedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dado_in;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pop only from OCIOSO, and only once the HPS has released ack; a word written
  // into an empty FIFO is therefore popped one edge later, never bypassed.
  always_comb begin
    estado_d = estado_q;
    req_d    = req_q;
    dado_d   = dado_q;
    rd_en    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (!fifo_vazia && !ack_sinc_q) begin
          rd_en    = 1'b1;
          dado_d   = mem_q[rd_ptr_q];
          req_d    = 1'b1;
          estado_d = REQ_ALTO;
        end
      end
      REQ_ALTO: begin
        if (ack_sinc_q) begin
          req_d    = 1'b0;
          estado_d = REQ_BAIXO;
        end
      end
      REQ_BAIXO: begin
        if (!ack_sinc_q) estado_d = OCIOSO;
      end
      default: begin
        req_d    = 1'b0;
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      req_q    <= 1'b0;
      dado_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      req_q    <= req_d;
      dado_q   <= dado_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
